// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bundle shared by both sides of the register slice.
// With ID_WIDTH = 0 the ID fields collapse to one bit that the bridge holds at '0.
interface rggen_axi4lite_if #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;

  logic                     awvalid;
  logic                     awready;
  logic [IDW-1:0]           awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [IDW-1:0]           bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [IDW-1:0]           arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [IDW-1:0]           rid;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arprot, input arready,
    input rvalid, rid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bid, bresp, input bready,
    input arvalid, arid, araddr, arprot, output arready,
    output rvalid, rid, rdata, rresp, input rready
  );
endinterface

// File: rtl/rggen_axi4lite_slice.sv
// AXI4-Lite register slice: one two-entry skid buffer per channel, or a wire
// pass-through where SLICE_MASK clears the channel bit.
module rggen_axi4lite_slice_channel #(
  parameter int WIDTH  = 1,
  parameter bit SLICED = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_payload,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_payload
);
  if (SLICED) begin : g_slice
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e           r_state;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in;
    logic             w_out;

    assign w_in  = i_valid & r_in_ready;
    assign w_out = r_main_valid & i_ready;

    // in_ready is registered, so a freed skid re-opens the input one edge later
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state      <= EMPTY;
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b0;
        r_main       <= '0;
        r_skid       <= '0;
      end else begin
        case (r_state)
          EMPTY: begin
            r_in_ready <= 1'b1;
            if (w_in) begin
              r_state      <= ONE;
              r_main_valid <= 1'b1;
              r_main       <= i_payload;
            end
          end
          ONE: begin
            if (w_in && !w_out) begin
              r_state      <= FULL;
              r_skid       <= i_payload;
              r_skid_valid <= 1'b1;
              r_in_ready   <= 1'b0;
            end else if (w_in) begin
              r_main <= i_payload;
            end else if (w_out) begin
              r_state      <= EMPTY;
              r_main_valid <= 1'b0;
            end
          end
          FULL: begin
            if (w_out) begin
              r_state      <= ONE;
              r_main       <= r_skid;
              r_skid_valid <= 1'b0;
              r_in_ready   <= 1'b1;
            end
          end
          default: begin
            r_state      <= EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
          end
        endcase
      end
    end

    assign o_ready   = r_in_ready;
    assign o_valid   = r_main_valid;
    assign o_payload = r_main;
  end else begin : g_pass
    assign o_ready   = i_ready;
    assign o_valid   = i_valid;
    assign o_payload = i_payload;
  end
endmodule

module rggen_axi4lite_slice #(
  parameter int       ID_WIDTH      = 0,
  parameter int       ADDRESS_WIDTH = 16,
  parameter int       BUS_WIDTH     = 32,
  parameter bit [4:0] SLICE_MASK    = 5'b11111
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_axi4lite_if.slave       slave_if,
  rggen_axi4lite_if.master      master_if
);
  localparam int IDW  = (ID_WIDTH > 0) ? ID_WIDTH : 1;
  localparam int A_W  = IDW + ADDRESS_WIDTH + 3;
  localparam int W_W  = BUS_WIDTH + BUS_WIDTH / 8;
  localparam int B_W  = IDW + 2;
  localparam int R_W  = IDW + BUS_WIDTH + 2;

  logic [A_W-1:0] w_aw_in, w_aw_out;
  logic [W_W-1:0] w_w_in,  w_w_out;
  logic [A_W-1:0] w_ar_in, w_ar_out;
  logic [B_W-1:0] w_b_in,  w_b_out;
  logic [R_W-1:0] w_r_in,  w_r_out;

  assign w_aw_in = {slave_if.awid, slave_if.awaddr, slave_if.awprot};
  assign {master_if.awid, master_if.awaddr, master_if.awprot} = w_aw_out;
  assign w_w_in  = {slave_if.wdata, slave_if.wstrb};
  assign {master_if.wdata, master_if.wstrb} = w_w_out;
  assign w_ar_in = {slave_if.arid, slave_if.araddr, slave_if.arprot};
  assign {master_if.arid, master_if.araddr, master_if.arprot} = w_ar_out;
  assign w_b_in  = {master_if.bid, master_if.bresp};
  assign {slave_if.bid, slave_if.bresp} = w_b_out;
  assign w_r_in  = {master_if.rid, master_if.rdata, master_if.rresp};
  assign {slave_if.rid, slave_if.rdata, slave_if.rresp} = w_r_out;

  rggen_axi4lite_slice_channel #(.WIDTH(A_W), .SLICED(SLICE_MASK[0])) u_aw (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(slave_if.awvalid), .o_ready(slave_if.awready), .i_payload(w_aw_in),
    .o_valid(master_if.awvalid), .i_ready(master_if.awready), .o_payload(w_aw_out)
  );

  rggen_axi4lite_slice_channel #(.WIDTH(W_W), .SLICED(SLICE_MASK[1])) u_w (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(slave_if.wvalid), .o_ready(slave_if.wready), .i_payload(w_w_in),
    .o_valid(master_if.wvalid), .i_ready(master_if.wready), .o_payload(w_w_out)
  );

  rggen_axi4lite_slice_channel #(.WIDTH(A_W), .SLICED(SLICE_MASK[2])) u_ar (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(slave_if.arvalid), .o_ready(slave_if.arready), .i_payload(w_ar_in),
    .o_valid(master_if.arvalid), .i_ready(master_if.arready), .o_payload(w_ar_out)
  );

  // Response channels flow from the downstream side back to the bridge
  rggen_axi4lite_slice_channel #(.WIDTH(B_W), .SLICED(SLICE_MASK[3])) u_b (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(master_if.bvalid), .o_ready(master_if.bready), .i_payload(w_b_in),
    .o_valid(slave_if.bvalid), .i_ready(slave_if.bready), .o_payload(w_b_out)
  );

  rggen_axi4lite_slice_channel #(.WIDTH(R_W), .SLICED(SLICE_MASK[4])) u_r (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(master_if.rvalid), .o_ready(master_if.rready), .i_payload(w_r_in),
    .o_valid(slave_if.rvalid), .i_ready(slave_if.rready), .o_payload(w_r_out)
  );
endmodule
